// File: rtl/adc_serial_ctrl.sv
// Round-robin sequencer for the two serial ADCs: sends the control byte, waits for both strobes, reads both DOUT lines.
// Build option: define ADC_SERIAL_OVERRUN_CNT_EN to include the 16-bit saturating overrun_cnt counter.
module adc_serial_ctrl #(
   parameter int CLK_DIV = 4,
   parameter int NUM_CH  = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        ad_dout0,
   input  logic        ad_dout1,
   input  logic        ad_sstrb0,
   input  logic        ad_sstrb1,
   output logic        ad_din,
   output logic        ad_sclk,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [11:0] out_data0,
   output logic [11:0] out_data1,
   output logic [2:0]  out_ch,
   output logic        timeout_flag,
   output logic        overrun_flag,
   output logic [15:0] overrun_cnt
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int TO_W  = $clog2(TIMEOUT + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
   localparam logic [2:0]       CH_LAST  = 3'(NUM_CH - 1);

   typedef enum logic [2:0] {IDLE, CMD, WAIT_STRB, READ, DONE} state_t;

   state_t           state_reg;
   logic [DIV_W-1:0] div_cnt_reg;
   logic [3:0]       bit_cnt_reg;
   logic             sclk_reg;
   logic             din_reg;
   logic [6:0]       cmd_sr_reg;
   logic [TO_W-1:0]  wait_cnt_reg;
   logic [2:0]       ch_reg;
   logic             out_valid_reg;
   logic [11:0]      out_data0_reg;
   logic [11:0]      out_data1_reg;
   logic [2:0]       out_ch_reg;
   logic             timeout_flag_reg;
   logic             overrun_flag_reg;

   logic [7:0]       ctrl_byte;
   logic             half_end;
   logic             sample_en;
   logic [2:0]       ch_next;
   logic             overrun_evt;
   logic [1:0]       dout_pin;
   logic [1:0]       strb_pin;
   logic [1:0]       strb_sync;
   logic [1:0][11:0] rx_word;

   // start, channel select, unipolar, single-ended, internal clock
   assign ctrl_byte   = {1'b1, ch_reg, 4'b1110};
   assign half_end    = (div_cnt_reg == DIV_LAST);
   assign sample_en   = (state_reg == READ) && half_end && sclk_reg && (bit_cnt_reg < 4'd12);
   assign ch_next     = (ch_reg == CH_LAST) ? 3'd0 : ch_reg + 3'd1;
   assign overrun_evt = (state_reg == DONE) && out_valid_reg && !out_ready;
   assign dout_pin    = {ad_dout1, ad_dout0};
   assign strb_pin    = {ad_sstrb1, ad_sstrb0};

   // Per-ADC lane: synchronizers plus capture of the first 12 received bits;
   // the trailing four bits of each 16-bit read carry no data and are not kept.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         logic [1:0]  dout_sync_reg;
         logic [1:0]  strb_sync_reg;
         logic [11:0] rx_sr_reg;

         always_ff @(posedge clk) begin
            if (reset) begin
               dout_sync_reg <= '0;
               strb_sync_reg <= '0;
               rx_sr_reg     <= '0;
            end else begin
               dout_sync_reg <= {dout_sync_reg[0], dout_pin[gi]};
               strb_sync_reg <= {strb_sync_reg[0], strb_pin[gi]};
               if (sample_en)
                  rx_sr_reg <= {rx_sr_reg[10:0], dout_sync_reg[1]};
            end
         end

         assign strb_sync[gi] = strb_sync_reg[1];
         assign rx_word[gi]   = rx_sr_reg;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= IDLE;
         div_cnt_reg      <= '0;
         bit_cnt_reg      <= '0;
         sclk_reg         <= 1'b0;
         din_reg          <= 1'b0;
         cmd_sr_reg       <= '0;
         wait_cnt_reg     <= '0;
         ch_reg           <= '0;
         out_valid_reg    <= 1'b0;
         out_data0_reg    <= '0;
         out_data1_reg    <= '0;
         out_ch_reg       <= '0;
         timeout_flag_reg <= 1'b0;
         overrun_flag_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               sclk_reg <= 1'b0;
               din_reg  <= 1'b0;
               if (enable) begin
                  state_reg   <= CMD;
                  din_reg     <= ctrl_byte[7];
                  cmd_sr_reg  <= ctrl_byte[6:0];
                  div_cnt_reg <= '0;
                  bit_cnt_reg <= '0;
               end
            end
            CMD: begin
               if (half_end) begin
                  div_cnt_reg <= '0;
                  sclk_reg    <= ~sclk_reg;
                  // end of a high phase: next bit goes out with the falling edge
                  if (sclk_reg) begin
                     if (bit_cnt_reg == 4'd7) begin
                        state_reg    <= WAIT_STRB;
                        din_reg      <= 1'b0;
                        wait_cnt_reg <= '0;
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        din_reg     <= cmd_sr_reg[6];
                        cmd_sr_reg  <= {cmd_sr_reg[5:0], 1'b0};
                     end
                  end
               end else begin
                  div_cnt_reg <= div_cnt_reg + DIV_W'(1);
               end
            end
            WAIT_STRB: begin
               if (&strb_sync) begin
                  state_reg   <= READ;
                  div_cnt_reg <= '0;
                  bit_cnt_reg <= '0;
               end else if (wait_cnt_reg == TO_LAST) begin
                  timeout_flag_reg <= 1'b1;
                  ch_reg           <= ch_next;
                  state_reg        <= IDLE;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + TO_W'(1);
               end
            end
            READ: begin
               if (half_end) begin
                  div_cnt_reg <= '0;
                  sclk_reg    <= ~sclk_reg;
                  if (sclk_reg) begin
                     if (bit_cnt_reg == 4'd15)
                        state_reg <= DONE;
                     else
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                  end
               end else begin
                  div_cnt_reg <= div_cnt_reg + DIV_W'(1);
               end
            end
            DONE: begin
               ch_reg    <= ch_next;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase

         // A new sample only replaces the held one if the held one leaves this cycle.
         if (overrun_evt) begin
            overrun_flag_reg <= 1'b1;
         end else if (state_reg == DONE) begin
            out_valid_reg <= 1'b1;
            out_data0_reg <= rx_word[0];
            out_data1_reg <= rx_word[1];
            out_ch_reg    <= ch_reg;
         end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

`ifdef ADC_SERIAL_OVERRUN_CNT_EN
   logic [15:0] overrun_cnt_reg;

   always_ff @(posedge clk) begin
      if (reset)
         overrun_cnt_reg <= '0;
      else if (overrun_evt && (overrun_cnt_reg != 16'hFFFF))
         overrun_cnt_reg <= overrun_cnt_reg + 16'd1;
   end

   assign overrun_cnt = overrun_cnt_reg;
`else
   assign overrun_cnt = 16'd0;
`endif

   assign ad_din       = din_reg;
   assign ad_sclk      = sclk_reg;
   assign out_valid    = out_valid_reg;
   assign out_data0    = out_data0_reg;
   assign out_data1    = out_data1_reg;
   assign out_ch       = out_ch_reg;
   assign timeout_flag = timeout_flag_reg;
   assign overrun_flag = overrun_flag_reg;

endmodule

// File: tb/tb_adc_serial_ctrl.sv
// Bench for adc_serial_ctrl: pin-level model of both ADCs plus a scoreboard of expected samples.
module tb_adc_serial_ctrl;

   localparam int CLK_DIV = 4;
   localparam int NUM_CH  = 8;
   localparam int TIMEOUT = 64;
`ifdef ADC_SERIAL_OVERRUN_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        ad_dout0 = 1'b0;
   logic        ad_dout1 = 1'b0;
   logic        ad_sstrb0 = 1'b0;
   logic        ad_sstrb1 = 1'b0;
   logic        out_ready = 1'b0;
   logic        ad_din;
   logic        ad_sclk;
   logic        out_valid;
   logic [11:0] out_data0;
   logic [11:0] out_data1;
   logic [2:0]  out_ch;
   logic        timeout_flag;
   logic        overrun_flag;
   logic [15:0] overrun_cnt;

   adc_serial_ctrl #(.CLK_DIV(CLK_DIV), .NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .ad_dout0(ad_dout0), .ad_dout1(ad_dout1),
      .ad_sstrb0(ad_sstrb0), .ad_sstrb1(ad_sstrb1),
      .ad_din(ad_din), .ad_sclk(ad_sclk),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data0(out_data0), .out_data1(out_data1), .out_ch(out_ch),
      .timeout_flag(timeout_flag), .overrun_flag(overrun_flag), .overrun_cnt(overrun_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  ch;
      logic [11:0] d0;
      logic [11:0] d1;
   } smp_t;

   smp_t sb_q[$];

   int checks = 0;
   int errors = 0;

   // requested input levels, applied at the next falling clock edge
   logic rst_req = 1'b1, en_req = 1'b0, rdy_req = 1'b0;
   logic to_mode = 1'b0, ready_at_done = 1'b0;

   int   mstate = 0, pos = 0, fall_cnt = 0, countdown = 0;
   int   cyc = 0, last_rise = 0, frames_done = 0, m_ovr_cnt = 0;
   logic sclk_prev = 1'b0, m_valid = 1'b0, m_ovr_flag = 1'b0, frame_to = 1'b0;
   logic [7:0]  cmd_sh = '0;
   logic [2:0]  exp_ch = '0, frame_ch = '0;
   logic [15:0] w0 = '0, w1 = '0;
   logic [15:0] next_w0 = 16'hABC0, next_w1 = 16'h1230;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_step();
      smp_t e;
      logic done_now;
      cyc++;
      reset     = rst_req;
      enable    = en_req;
      out_ready = rdy_req;
      done_now  = 1'b0;
      if (reset) begin
         mstate = 0; pos = 0; fall_cnt = 0; countdown = 0;
         ad_sstrb0 = 1'b0; ad_sstrb1 = 1'b0; ad_dout0 = 1'b0; ad_dout1 = 1'b0;
         exp_ch = '0; m_valid = 1'b0; m_ovr_cnt = 0; m_ovr_flag = 1'b0;
         sb_q.delete();
         sclk_prev = 1'b0;
         return;
      end
      if (ad_sclk && !sclk_prev) begin
         ad_sstrb0 = 1'b0;
         ad_sstrb1 = 1'b0;
         if (mstate == 0) begin
            if (pos > 0)
               check_val("sclk_period", cyc - last_rise, 2 * CLK_DIV);
            cmd_sh = {cmd_sh[6:0], ad_din};
            pos++;
            if (pos == 8) begin
               check_val("cmd_byte", {24'd0, cmd_sh}, {24'd0, 1'b1, exp_ch, 4'b1110});
               frame_ch = exp_ch;
               exp_ch   = (int'(exp_ch) == NUM_CH - 1) ? 3'd0 : exp_ch + 3'd1;
               frame_to = to_mode;
               w0 = next_w0; w1 = next_w1;
               next_w0 = 16'($urandom); next_w1 = 16'($urandom);
               countdown = 20; mstate = 1; pos = 0;
               if (frame_to) frames_done++;
            end
         end
         last_rise = cyc;
      end else if (!ad_sclk && sclk_prev && mstate == 2) begin
         fall_cnt++;
         if (fall_cnt < 16) begin
            ad_dout0 = w0[15 - fall_cnt];
            ad_dout1 = w1[15 - fall_cnt];
         end else begin
            done_now = 1'b1; mstate = 0; ad_dout0 = 1'b0; ad_dout1 = 1'b0;
            frames_done++;
         end
      end
      sclk_prev = ad_sclk;
      if (mstate == 1) begin
         countdown--;
         if (countdown == 0) begin
            ad_sstrb0 = 1'b1;
            ad_sstrb1 = !frame_to;
            if (frame_to) mstate = 0;
            else begin
               mstate = 2; fall_cnt = 0;
               ad_dout0 = w0[15]; ad_dout1 = w1[15];
            end
         end
      end
      if (done_now && ready_at_done) begin
         out_ready = 1'b1;
         ready_at_done = 1'b0;
      end
      check_val("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      check_val("overrun_flag", {31'd0, overrun_flag}, {31'd0, m_ovr_flag});
      check_val("overrun_cnt", {16'd0, overrun_cnt}, CNT_EN ? m_ovr_cnt : 0);
      if (out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            check_val("sb_nonempty", sb_q.size(), 1);
         end else begin
            e = sb_q.pop_front();
            check_val("out_ch", {29'd0, out_ch}, {29'd0, e.ch});
            check_val("out_data0", {20'd0, out_data0}, {20'd0, e.d0});
            check_val("out_data1", {20'd0, out_data1}, {20'd0, e.d1});
            $display("xfer ch=%0d d0=0x%h d1=0x%h (expected ch=%0d d0=0x%h d1=0x%h)",
                     out_ch, out_data0, out_data1, e.ch, e.d0, e.d1);
         end
      end
      if (done_now) begin
         if (m_valid && !out_ready) begin
            m_ovr_flag = 1'b1;
            if (m_ovr_cnt < 65535) m_ovr_cnt++;
         end else begin
            m_valid = 1'b1;
            sb_q.push_back({frame_ch, w0[15:4], w1[15:4]});
         end
      end else if (m_valid && out_ready) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model_step();
   endtask

   task automatic wait_frames(input int n);
      int target = frames_done + n;
      int lim = 0;
      while (frames_done < target && lim < 600 * n) begin
         tick();
         lim++;
      end
      if (frames_done < target)
         check_val("frame_wait", frames_done, target);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_sclk"}, {31'd0, ad_sclk}, 0);
      check_val({tag, "_din"}, {31'd0, ad_din}, 0);
      check_val({tag, "_valid"}, {31'd0, out_valid}, 0);
      check_val({tag, "_data0"}, {20'd0, out_data0}, 0);
      check_val({tag, "_data1"}, {20'd0, out_data1}, 0);
      check_val({tag, "_ch"}, {29'd0, out_ch}, 0);
      check_val({tag, "_tflag"}, {31'd0, timeout_flag}, 0);
      check_val({tag, "_oflag"}, {31'd0, overrun_flag}, 0);
      check_val({tag, "_ocnt"}, {16'd0, overrun_cnt}, 0);
   endtask

   initial begin
      int lim;
      repeat (3) tick();
      check_reset_outputs("rst");

      // first frame carries 0xABC0/0x1230, then a full scan ending back on channel 0
      rst_req = 1'b0; en_req = 1'b1; rdy_req = 1'b1;
      wait_frames(9);

      // three frames with the sink stalled: first held, two dropped
      rdy_req = 1'b0;
      wait_frames(3);
      tick();
      check_val("ovr_flag_after3", {31'd0, overrun_flag}, 1);
      check_val("ovr_cnt_after3", {16'd0, overrun_cnt}, CNT_EN ? 2 : 0);
      rdy_req = 1'b1;
      repeat (3) tick();
      check_val("sb_drained", sb_q.size(), 0);

      // ready rises exactly in the DONE cycle: old sample leaves, new one loads
      rdy_req = 1'b0;
      wait_frames(1);
      ready_at_done = 1'b1;
      wait_frames(1);
      tick();
      check_val("ovr_cnt_same_cycle", {16'd0, overrun_cnt}, CNT_EN ? 2 : 0);
      check_val("valid_after_reload", {31'd0, out_valid}, 1);
      rdy_req = 1'b1;
      repeat (3) tick();

      // reset in the middle of READ while a sample is held
      rdy_req = 1'b0;
      wait_frames(1);
      lim = 0;
      while (!(mstate == 2 && fall_cnt >= 5) && lim < 1000) begin
         tick();
         lim++;
      end
      check_val("reach_mid_read", {31'd0, (mstate == 2)}, 1);
      rst_req = 1'b1;
      tick();
      rst_req = 1'b0; rdy_req = 1'b1; to_mode = 1'b1;
      tick();
      check_reset_outputs("midrst");

      // channel 0 frame times out (only strobe0), next frame must use channel 1
      wait_frames(1);
      to_mode = 1'b0;
      wait_frames(1);
      tick();
      check_val("timeout_flag", {31'd0, timeout_flag}, 1);
      check_val("sb_final", sb_q.size(), 0);

      en_req = 1'b0;
      repeat (5) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/adc_serial_ctrl.md
# adc_serial_ctrl

Sequencer for the two serial ADCs on the DE4 analog header. Drives the shared `AD_DIN`/`AD_SCLK` pins, waits for both `AD_SSTRB` strobes, and shifts in both `AD_DOUT` lines in parallel. It emits one paired 12-bit sample per channel, scanning the channels round-robin. The block sits between the board pins and the acquisition/DMA logic in the PCIe system, feeding that logic through a valid/ready stream.

## Interface
- `CLK_DIV`, 4: clk cycles per SCLK half-period (≥2); SCLK period = 2·CLK_DIV.
- `NUM_CH`, 8: channels scanned, 1..8; channel index is 0..NUM_CH-1.
- `TIMEOUT`, 1024: max clk cycles spent in WAIT_STRB before abandoning the conversion.
- `clk` in 1: system clock (50 MHz, OSC_50_BANK2 domain).
- `reset` in 1: synchronous, active-high.
- `enable` in 1: scanning allowed; sampled only in IDLE.
- `ad_dout0`, `ad_dout1` in 1: ADC serial data, asynchronous.
- `ad_sstrb0`, `ad_sstrb1` in 1: ADC end-of-conversion strobes, asynchronous.
- `ad_din` out 1: control-byte serial data.
- `ad_sclk` out 1: serial clock.
- `out_valid` out 1, `out_ready` in 1: output stream handshake.
- `out_data0`, `out_data1` out 12: samples from ADC0 and ADC1.
- `out_ch` out 3: channel index of the sample pair.
- `timeout_flag` out 1: sticky; set on a WAIT_STRB timeout, cleared by reset.
- `overrun_flag` out 1: sticky; set when a completed sample is dropped, cleared by reset.
- `overrun_cnt` out 16: dropped-sample count (see Configuration).

## Operation
- Synchronizers: `ad_sstrb*` and `ad_dout*` each pass through a 2-flop synchronizer. All decisions use the synchronized values.
- Control byte for channel c: `{1'b1, c[2:0], 1'b1, 1'b1, 2'b10}`. This is start, select, unipolar, single-ended, internal clock. Channel 0 = 0x8E, channel 3 = 0xBE.
- State IDLE: `ad_sclk`=0 and `ad_din`=0. If `enable`=1, go to CMD.
- State CMD: shift 8 bits MSB first.
  - `ad_din` updates on the first cycle of each SCLK low phase.
  - After 8 SCLK periods, go to WAIT_STRB with `ad_sclk`=0.
- State WAIT_STRB: wait for both synchronized strobes to be 1.
  - If both are 1, go to READ.
  - If the wait counter reaches TIMEOUT-1 first: set `timeout_flag`, advance the channel, go to IDLE. No sample is produced.
- State READ: 16 SCLK periods; `ad_din`=0.
  - Both synchronized DOUTs are sampled into 16-bit shift registers on the last clk of each SCLK high phase.
  - The result is bits [15:4] of each shift register (first 12 bits received, MSB first).
- State DONE (1 cycle): load the output register, advance the channel, go to IDLE.
  - Channel wraps from NUM_CH-1 to 0.
- Output register:
  - Handshake transfers on `out_valid`&&`out_ready`.
  - `out_valid` deasserts on transfer unless DONE reloads it in the same cycle.
  - If DONE occurs while `out_valid`=1 and `out_ready`=0: the new sample is dropped, the old sample is held unchanged, `overrun_flag` is set, and `overrun_cnt` increments, saturating at 0xFFFF.
  - If `out_ready`=1 in that same cycle, the old sample transfers and the new one loads; this is not an overrun.
- `enable` deasserted mid-frame: the current frame completes. The block stops in IDLE.
- `reset` mid-frame: immediate return to IDLE; the shift registers are discarded.

## Timing
- Reset values: `ad_sclk`=0, `ad_din`=0, `out_valid`=0, `out_data0`=0, `out_data1`=0, `out_ch`=0, both flags 0, `overrun_cnt`=0. Internal state: channel=0, state IDLE.
- SCLK low phase comes first in every bit; duty cycle is 50%.
- CMD lasts 16·CLK_DIV cycles. READ lasts 16·CLK_DIV cycles.
- Strobe detection latency is 2 synchronizer cycles + 1 cycle.
- `out_valid` rises 2 cycles after the final SCLK high phase ends (last READ cycle, then DONE).
- Frame with CLK_DIV=4 and an immediate strobe: 1 + 64 + 3 + 64 + 1 = 133 cycles.

## Configuration
- `ADC_SERIAL_OVERRUN_CNT_EN`:
  - Defined: the 16-bit saturating `overrun_cnt` counter is built.
  - Undefined: `overrun_cnt` is tied to 0, and `overrun_flag` still operates.

## Test plan
- Reset, then `enable`=1, strobes high after 20 cycles, DOUT0 streaming 0xABC0 and DOUT1 streaming 0x1230 → DIN carries 0x8E; `out_data0`=0xABC, `out_data1`=0x123, `out_ch`=0. Check SCLK period = 8 cycles.
- Continuous scan with NUM_CH=8 and `out_ready`=1 → `out_ch` sequence 0..7,0; the DIN byte for channel 3 = 0xBE.
- Only `ad_sstrb0` asserts, TIMEOUT=64 → `timeout_flag`=1 and no `out_valid`; the next frame uses channel 1.
- `out_ready`=0 across 3 frames → the first sample is held, `overrun_flag`=1, `overrun_cnt`=2 (0 without the macro).
- `out_ready` rises in the same cycle as DONE → the old sample transfers, the new one loads, and `overrun_cnt` is unchanged.
- Assert `reset` mid-READ → all outputs return to their reset values next cycle; the subsequent frame uses channel 0.
